// File: rtl/serial_arithmetic_left_shift_saturating.sv
// Serial signed multiply by 2^shamt: one arithmetic left shift per clock.
// Overflow is sticky and saturates the result to the limit of the captured operand sign.
module serial_arithmetic_left_shift_saturating #(
  parameter int W  = 8,
  parameter int SW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [W-1:0]  up_data,
  input  logic [SW-1:0] up_shamt,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [W-1:0]  down_data,
  output logic          down_ovf
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t        state;
  logic [W-1:0]  cur;
  logic [SW-1:0] cnt;
  logic          sign;
  logic          ovf;

  logic [W-1:0]  shifted;
  logic [W-1:0]  sat_val;
  logic          step_ovf;

  // A step overflows when the bit about to become the sign differs from the current sign.
  always_comb begin
    shifted  = {cur[W-2:0], 1'b0};
    step_ovf = ovf | (cur[W-1] ^ cur[W-2]);
    sat_val  = sign ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end

  assign up_ready   = (state == IDLE);
  assign down_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur       <= '0;
      cnt       <= '0;
      sign      <= 1'b0;
      ovf       <= 1'b0;
      down_data <= '0;
      down_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (up_valid) begin
            cur  <= up_data;
            cnt  <= up_shamt;
            sign <= up_data[W-1];
            ovf  <= 1'b0;
            if (up_shamt == '0) begin
              down_data <= up_data;
              down_ovf  <= 1'b0;
              state     <= DONE;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          cur <= shifted;
          ovf <= step_ovf;
          cnt <= cnt - 1'b1;
          // Result is latched on the final step so it stays frozen throughout DONE.
          if (cnt == SW'(1)) begin
            down_data <= step_ovf ? sat_val : shifted;
            down_ovf  <= step_ovf;
            state     <= DONE;
          end
        end
        DONE: begin
          if (down_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_arithmetic_left_shift_saturating.sv
// Directed and randomised checks of the serial saturating left shifter at W=8.
// Inputs change on the falling edge; outputs are sampled on the falling edge or #1 after the rising edge.
module tb_serial_arithmetic_left_shift_saturating;

  localparam int W  = 8;
  localparam int SW = 4;

  logic          clk;
  logic          rst;
  logic          up_valid;
  logic          up_ready;
  logic [W-1:0]  up_data;
  logic [SW-1:0] up_shamt;
  logic          down_valid;
  logic          down_ready;
  logic [W-1:0]  down_data;
  logic          down_ovf;

  int checks;
  int passes;

  serial_arithmetic_left_shift_saturating #(.W(W), .SW(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .up_valid  (up_valid),
    .up_ready  (up_ready),
    .up_data   (up_data),
    .up_shamt  (up_shamt),
    .down_valid(down_valid),
    .down_ready(down_ready),
    .down_data (down_data),
    .down_ovf  (down_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Mathematical reference: a * 2^s clamped to the signed W-bit range.
  function automatic logic [W:0] satShift(input logic [W-1:0] a, input int s);
    longint v;
    v = longint'($signed(a));
    for (int i = 0; i < s; i++) begin
      v = v * 2;
      if (v > 1000000 || v < -1000000) break;
    end
    if (v > 127)       return {1'b1, 8'h7F};
    else if (v < -128) return {1'b1, 8'h80};
    else               return {1'b0, v[7:0]};
  endfunction

  // Send one operand, check latency and result, stall for 'stall' cycles, then take the result.
  task automatic applyStimulus(input string tag, input logic [W-1:0] d, input logic [SW-1:0] s,
                               input logic [W-1:0] expData, input logic expOvf, input int stall);
    int lat;
    @(negedge clk);
    checkOutput({tag, " ready_idle"}, up_ready, 1);
    up_valid   = 1'b1;
    up_data    = d;
    up_shamt   = s;
    down_ready = 1'b0;
    @(posedge clk);
    #1;
    up_valid = 1'b0;
    up_data  = 8'hA5;
    up_shamt = 4'hF;
    lat = 1;
    @(negedge clk);
    while (!down_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, " latency"}, lat, 32'(s) + 1);
    checkOutput({tag, " data"}, down_data, expData);
    checkOutput({tag, " ovf"}, down_ovf, expOvf);
    checkOutput({tag, " ready_busy"}, up_ready, 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checkOutput({tag, " stall_valid"}, down_valid, 1);
      checkOutput({tag, " stall_data"}, down_data, expData);
      checkOutput({tag, " stall_ovf"}, down_ovf, expOvf);
      checkOutput({tag, " stall_ready"}, up_ready, 0);
    end
    down_ready = 1'b1;
    @(posedge clk);
    #1;
    down_ready = 1'b0;
    checkOutput({tag, " post_valid"}, down_valid, 0);
    checkOutput({tag, " post_ready"}, up_ready, 1);
  endtask

  initial begin
    logic [W:0]    m;
    logic [W-1:0]  rd;
    logic [SW-1:0] rs;
    checks     = 0;
    passes     = 0;
    rst        = 1'b1;
    up_valid   = 1'b0;
    up_data    = '0;
    up_shamt   = '0;
    down_ready = 1'b0;
    #2;
    checkOutput("reset up_ready", up_ready, 1);
    checkOutput("reset down_valid", down_valid, 0);
    checkOutput("reset down_data", down_data, 0);
    checkOutput("reset down_ovf", down_ovf, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    applyStimulus("pos3",   8'h05, 4'd3,  8'h28, 1'b0, 0);
    applyStimulus("neg2",   8'hFB, 4'd2,  8'hEC, 1'b0, 0);
    applyStimulus("zero_s", 8'h80, 4'd0,  8'h80, 1'b0, 0);
    applyStimulus("ovf_p",  8'h30, 4'd2,  8'h7F, 1'b1, 0);
    applyStimulus("ovf_n",  8'h90, 4'd1,  8'h80, 1'b1, 0);
    applyStimulus("exact",  8'hFF, 4'd7,  8'h80, 1'b0, 0);
    applyStimulus("zero15", 8'h00, 4'd15, 8'h00, 1'b0, 0);
    applyStimulus("one15",  8'h01, 4'd15, 8'h7F, 1'b1, 0);
    applyStimulus("bp",     8'hC0, 4'd1,  8'h80, 1'b0, 5);
    applyStimulus("bp_next", 8'h03, 4'd4, 8'h30, 1'b0, 0);

    // Reset in the middle of SHIFT aborts the operation.
    @(negedge clk);
    up_valid = 1'b1;
    up_data  = 8'h05;
    up_shamt = 4'd3;
    @(posedge clk);
    #1;
    up_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_shift down_valid", down_valid, 0);
    checkOutput("rst_shift up_ready", up_ready, 1);
    checkOutput("rst_shift down_data", down_data, 0);
    checkOutput("rst_shift down_ovf", down_ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("rst_shift no_result", down_valid, 0);
    applyStimulus("after_rst", 8'h07, 4'd2, 8'h1C, 1'b0, 0);

    // Reset while a saturated result waits in DONE.
    @(negedge clk);
    up_valid = 1'b1;
    up_data  = 8'h70;
    up_shamt = 4'd1;
    @(posedge clk);
    #1;
    up_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_done pre_valid", down_valid, 1);
    rst = 1'b1;
    #1;
    checkOutput("rst_done down_valid", down_valid, 0);
    checkOutput("rst_done down_data", down_data, 0);
    checkOutput("rst_done down_ovf", down_ovf, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      rd = 8'($urandom);
      rs = 4'($urandom_range(0, 15));
      m  = satShift(rd, int'(rs));
      applyStimulus($sformatf("rand%0d", i), rd, rs, m[W-1:0], m[W], int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
